lock_sequencer: RTL and testbench
=================================

LOCK_SEQUENCER -- requirements
Module: lock_sequencer

Interface
REQ-001 SHALL have parameter N_DIGITS, default 6, number of BCD digits per code entry.
REQ-002 SHALL have parameter MAX_FAILS, default 3, consecutive failed entries before lockout.
REQ-003 SHALL have parameter LOCKOUT_CYCLES, default 16, lockout duration in clk cycles.
REQ-004 SHALL have parameter CODE, default 24'h703262, reset/default code; 4-bit BCD per digit, first-entered digit in the MS nibble.
REQ-005 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port digit_valid  in  1  requester offers a digit.
REQ-008 SHALL have port digit  in  4  offered digit value.
REQ-009 SHALL have port digit_ready  out  1  sequencer accepts a digit this cycle.
REQ-010 SHALL have port clear  in  1  single-cycle acknowledge/abort pulse.
REQ-011 SHALL have port prog  in  1  request code reprogramming; functional only per REQ-033.
REQ-012 SHALL have port state_o  out  3  current state code, from lock_pkg.
REQ-013 SHALL have port digits_entered  out  3  digits accepted in the current entry.
REQ-014 SHALL have port fails  out  2  consecutive failed entries.
REQ-015 SHALL have port lockout_left  out  5  remaining lockout cycles, 0 outside LOCKOUT.

Function
REQ-016 SHALL implement states ENTRY, OPEN, CLOSED, ERROR, LOCKOUT, PROG.
REQ-017 SHALL drive digit_ready = (state is ENTRY or PROG) and not clear; a digit is accepted only on digit_valid and digit_ready.
REQ-018 SHALL, in ENTRY, on accepting a digit > 9, go to ERROR next cycle without changing fails.
REQ-019 SHALL, in ENTRY, compare each accepted digit against the code nibble at index digits_entered, increment digits_entered, and set a sticky mismatch flag on inequality.
REQ-020 SHALL, on accepting digit N_DIGITS with no mismatch, enter OPEN next cycle and clear fails.
REQ-021 SHALL, on accepting digit N_DIGITS with a mismatch, increment fails and enter LOCKOUT if the new fails equals MAX_FAILS, otherwise enter CLOSED.
REQ-022 SHALL, in ENTRY, on clear, zero digits_entered and the mismatch flag while staying in ENTRY.
REQ-023 SHALL leave OPEN, CLOSED and ERROR for ENTRY on clear, zeroing digits_entered and the mismatch flag.
REQ-024 SHALL, on LOCKOUT entry, load lockout_left with LOCKOUT_CYCLES and decrement it by one each cycle.
REQ-025 SHALL leave LOCKOUT for ENTRY on the cycle after lockout_left equals 1, with fails cleared to 0.
REQ-026 SHALL ignore clear, prog and digit_valid in LOCKOUT.
REQ-027 SHALL make every output a function of registered state only, so an accepted digit's effect is visible the cycle after acceptance.
REQ-028 SHALL saturate fails at MAX_FAILS and never wrap digits_entered past N_DIGITS.

Reset
REQ-029 SHALL, on rst, force state ENTRY, digits_entered 0, fails 0, lockout_left 0, mismatch flag 0, code register CODE.
REQ-030 SHALL give rst priority over every other input, including mid-entry, mid-lockout and mid-programming.

Configuration
REQ-031 SHALL use macro LOCK_PROG_EN to enable reprogramming.
REQ-032 SHALL, without LOCK_PROG_EN, hold the code constant at CODE, ignore prog, and never reach PROG.
REQ-033 SHALL, with LOCK_PROG_EN, enter PROG from OPEN on prog (prog wins over a simultaneous clear).
REQ-034 SHALL, in PROG, store N_DIGITS accepted digits into the code register, reject digits > 9 without storing or advancing, enter CLOSED after the last digit, and return to ENTRY on clear with the old code unchanged.

Structure
REQ-035 SHALL take the state enum and state-code constants from shared package lock_pkg.
REQ-036 SHALL implement the lockout down-counter as sub-module lock_timer (load, decrement, done).

Verification
REQ-037 SHALL cover: digits 7,0,3,2,6,2 -> state_o OPEN the cycle after the 6th accept, fails 0.
REQ-038 SHALL cover: 7,0,3,2,6,1 -> CLOSED, fails 1; clear -> ENTRY, digits_entered 0.
REQ-039 SHALL cover: three wrong entries -> LOCKOUT, lockout_left 16 counting down, digit_ready 0, then ENTRY with fails 0 after 16 cycles.
REQ-040 SHALL cover: digit 12 as the 2nd digit -> ERROR, fails unchanged; clear -> ENTRY.
REQ-041 SHALL cover: rst after 3 accepted digits -> ENTRY, digits_entered 0; then the correct code -> OPEN.
REQ-042 SHALL cover, with LOCK_PROG_EN: OPEN, prog, then 1,1,1,1,1,1 -> CLOSED; clear, then 1,1,1,1,1,1 -> OPEN; clear, then 7,0,3,2,6,2 -> CLOSED.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and widths for the digit-entry lock sequencer and its lockout timer.
package lock_pkg;

  localparam int DIGIT_W   = 4;
  localparam int CNT_W     = 3;
  localparam int FAILS_W   = 2;
  localparam int LOCKOUT_W = 5;

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_OPEN    = 3'd1,
    ST_CLOSED  = 3'd2,
    ST_ERROR   = 3'd3,
    ST_LOCKOUT = 3'd4,
    ST_PROG    = 3'd5
  } lock_state_t;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that times the lockout period; done flags the final cycle.
module lock_timer #(
  parameter int W        = 5,
  parameter int LOAD_VAL = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_done
);

  logic [W-1:0] r_count;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= W'(LOAD_VAL);
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_done  = (r_count == W'(1));

endmodule

// File: rtl/lock_sequencer.sv
// Digit-entry lock: compares BCD digits against a code, counts failures, times lockouts.
// Define LOCK_PROG_EN to allow reprogramming the code from the OPEN state.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int                    N_DIGITS       = 6,
  parameter int                    MAX_FAILS      = 3,
  parameter int                    LOCKOUT_CYCLES = 16,
  parameter logic [4*N_DIGITS-1:0] CODE           = 24'h703262
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 digit_valid,
  input  logic [DIGIT_W-1:0]   digit,
  output logic                 digit_ready,
  input  logic                 clear,
  input  logic                 prog,
  output logic [2:0]           state_o,
  output logic [CNT_W-1:0]     digits_entered,
  output logic [FAILS_W-1:0]   fails,
  output logic [LOCKOUT_W-1:0] lockout_left
);

  localparam int                   CODE_W      = DIGIT_W * N_DIGITS;
  localparam logic [CNT_W-1:0]     LAST_IDX    = CNT_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0]     N_CNT       = CNT_W'(N_DIGITS);
  localparam logic [FAILS_W-1:0]   FAILS_LIMIT = FAILS_W'(MAX_FAILS);
  localparam logic [CODE_W-1:0]    NIB_MASK    = CODE_W'(4'hF);

  lock_state_t          r_state, w_state_nx;
  logic [CNT_W-1:0]     r_digits, w_digits_nx;
  logic                 r_mismatch, w_mismatch_nx;
  logic [FAILS_W-1:0]   r_fails, w_fails_nx, w_fails_inc;
  logic                 w_timer_load, w_timer_dec, w_timer_done;
  logic [LOCKOUT_W-1:0] w_lockout_left;
  logic [CODE_W-1:0]    w_code, w_code_shifted;
  logic [CNT_W-1:0]     w_idx;
  int                   w_shift;
  logic [DIGIT_W-1:0]   w_code_nib;
  logic                 w_ready, w_accept, w_last, w_bcd;

  assign w_ready  = ((r_state == ST_ENTRY) || (r_state == ST_PROG)) && !clear;
  assign w_accept = digit_valid && w_ready;
  assign w_last   = (r_digits == LAST_IDX);
  assign w_bcd    = is_bcd(digit);

  // Index 0 is the first-entered digit and lives in the most significant nibble.
  assign w_idx          = (r_digits < N_CNT) ? r_digits : '0;
  assign w_shift        = DIGIT_W * (N_DIGITS - 1 - int'(w_idx));
  assign w_code_shifted = w_code >> w_shift;
  assign w_code_nib     = w_code_shifted[DIGIT_W-1:0];

  assign w_fails_inc = (r_fails >= FAILS_LIMIT) ? r_fails : r_fails + FAILS_W'(1);

`ifdef LOCK_PROG_EN
  localparam logic PROG_EN = 1'b1;

  logic [CODE_W-1:0] r_code, r_new_code, w_new_code_nx;
  logic              w_store, w_commit;

  // New digits collect in a shadow copy so an aborted programming run leaves the live code intact.
  assign w_store  = (r_state == ST_PROG) && w_accept && w_bcd;
  assign w_commit = w_store && w_last;

  always_comb begin
    w_new_code_nx = r_new_code;
    if (w_store) begin
      w_new_code_nx = (r_new_code & ~(NIB_MASK << w_shift)) | (CODE_W'(digit) << w_shift);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_code     <= CODE;
      r_new_code <= CODE;
    end else begin
      r_new_code <= w_new_code_nx;
      if (w_commit) begin
        r_code <= w_new_code_nx;
      end
    end
  end

  assign w_code = r_code;
`else
  localparam logic PROG_EN = 1'b0;

  assign w_code = CODE;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nx    = r_state;
    w_digits_nx   = r_digits;
    w_mismatch_nx = r_mismatch;
    w_fails_nx    = r_fails;
    w_timer_load  = 1'b0;

    case (r_state)
      ST_ENTRY: begin
        if (clear) begin
          w_digits_nx   = '0;
          w_mismatch_nx = 1'b0;
        end else if (w_accept) begin
          if (!w_bcd) begin
            w_state_nx = ST_ERROR;
          end else begin
            w_digits_nx   = r_digits + CNT_W'(1);
            w_mismatch_nx = r_mismatch | (digit != w_code_nib);
            if (w_last) begin
              if (!w_mismatch_nx) begin
                w_state_nx = ST_OPEN;
                w_fails_nx = '0;
              end else begin
                w_fails_nx = w_fails_inc;
                if (w_fails_inc == FAILS_LIMIT) begin
                  w_state_nx   = ST_LOCKOUT;
                  w_timer_load = 1'b1;
                end else begin
                  w_state_nx = ST_CLOSED;
                end
              end
            end
          end
        end
      end

      ST_OPEN: begin
        if (PROG_EN && prog) begin
          w_state_nx    = ST_PROG;
          w_digits_nx   = '0;
          w_mismatch_nx = 1'b0;
        end else if (clear) begin
          w_state_nx    = ST_ENTRY;
          w_digits_nx   = '0;
          w_mismatch_nx = 1'b0;
        end
      end

      ST_CLOSED, ST_ERROR: begin
        if (clear) begin
          w_state_nx    = ST_ENTRY;
          w_digits_nx   = '0;
          w_mismatch_nx = 1'b0;
        end
      end

      ST_LOCKOUT: begin
        if (w_timer_done) begin
          w_state_nx    = ST_ENTRY;
          w_fails_nx    = '0;
          w_digits_nx   = '0;
          w_mismatch_nx = 1'b0;
        end
      end

      ST_PROG: begin
        if (clear) begin
          w_state_nx    = ST_ENTRY;
          w_digits_nx   = '0;
          w_mismatch_nx = 1'b0;
        end else if (w_accept && w_bcd) begin
          w_digits_nx = r_digits + CNT_W'(1);
          if (w_last) begin
            w_state_nx = ST_CLOSED;
          end
        end
      end

      default: begin
        w_state_nx    = ST_ENTRY;
        w_digits_nx   = '0;
        w_mismatch_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_ENTRY;
      r_digits   <= '0;
      r_mismatch <= 1'b0;
      r_fails    <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_digits   <= w_digits_nx;
      r_mismatch <= w_mismatch_nx;
      r_fails    <= w_fails_nx;
    end
  end

  assign w_timer_dec = (r_state == ST_LOCKOUT);

  lock_timer #(
    .W        (LOCKOUT_W),
    .LOAD_VAL (LOCKOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_timer_load),
    .i_dec   (w_timer_dec),
    .o_count (w_lockout_left),
    .o_done  (w_timer_done)
  );

  assign digit_ready    = w_ready;
  assign state_o        = r_state;
  assign digits_entered = r_digits;
  assign fails          = r_fails;
  assign lockout_left   = w_lockout_left;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer; define LOCK_PROG_EN to also exercise code reprogramming.
module tb_lock_sequencer;
  import lock_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       digit_ready;
  logic       clear = 1'b0;
  logic       prog = 1'b0;
  logic [2:0] state_o;
  logic [2:0] digits_entered;
  logic [1:0] fails;
  logic [4:0] lockout_left;

  int n_checks = 0;
  int n_errors = 0;

  localparam int S_ENTRY = 0, S_OPEN = 1, S_CLOSED = 2, S_ERROR = 3, S_LOCKOUT = 4, S_PROG = 5;

  lock_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .digit_valid    (digit_valid),
    .digit          (digit),
    .digit_ready    (digit_ready),
    .clear          (clear),
    .prog           (prog),
    .state_o        (state_o),
    .digits_entered (digits_entered),
    .fails          (fails),
    .lockout_left   (lockout_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Offers one digit for a single cycle; returns on the negedge after the accepting edge.
  task automatic send_digit(input logic [3:0] d);
    @(negedge clk);
    digit_valid = 1'b1;
    digit       = d;
    @(negedge clk);
    digit_valid = 1'b0;
  endtask

  task automatic enter_code(input logic [23:0] c);
    for (int i = 0; i < 6; i++) send_digit(c[23-4*i -: 4]);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_state", state_o, S_ENTRY);
    check("rst_digits", digits_entered, 0);
    check("rst_fails", fails, 0);
    check("rst_lockout", lockout_left, 0);
    check("rst_ready", digit_ready, 1);

    // Correct code opens
    enter_code(24'h70326);
    send_digit(4'd7);
    enter_code(24'h000000);
    pulse_rst();
    for (int i = 0; i < 5; i++) send_digit(4'(i == 0 ? 7 : i == 1 ? 0 : i == 2 ? 3 : i == 3 ? 2 : 6));
    check("part_digits", digits_entered, 5);
    check("part_state", state_o, S_ENTRY);
    send_digit(4'd2);
    check("open_state", state_o, S_OPEN);
    check("open_fails", fails, 0);
    check("open_ready", digit_ready, 0);

`ifndef LOCK_PROG_EN
    @(negedge clk);
    prog = 1'b1;
    @(negedge clk);
    prog = 1'b0;
    check("prog_ignored", state_o, S_OPEN);
`endif
    pulse_clear();
    check("open_clr_state", state_o, S_ENTRY);
    check("open_clr_digits", digits_entered, 0);

    // One wrong digit closes
    enter_code(24'h703261);
    check("closed_state", state_o, S_CLOSED);
    check("closed_fails", fails, 1);
    pulse_clear();
    check("closed_clr_state", state_o, S_ENTRY);
    check("closed_clr_digits", digits_entered, 0);

    // Second and third wrong entries lead to lockout
    enter_code(24'h111111);
    check("fail2_state", state_o, S_CLOSED);
    check("fail2_fails", fails, 2);
    pulse_clear();
    enter_code(24'h000000);
    check("lock_state", state_o, S_LOCKOUT);
    check("lock_fails", fails, 3);
    check("lock_left16", lockout_left, 16);
    check("lock_ready", digit_ready, 0);
    clear = 1'b1;
    prog = 1'b1;
    digit_valid = 1'b1;
    digit = 4'd7;
    for (int k = 15; k >= 1; k--) begin
      @(negedge clk);
      check($sformatf("lock_left%0d", k), lockout_left, k);
      check($sformatf("lock_st%0d", k), state_o, S_LOCKOUT);
      if (k == 12) begin
        clear = 1'b0;
        prog = 1'b0;
        digit_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("unlock_state", state_o, S_ENTRY);
    check("unlock_fails", fails, 0);
    check("unlock_left", lockout_left, 0);
    check("unlock_digits", digits_entered, 0);

    // Clear in ENTRY blocks acceptance and drops a pending mismatch
    send_digit(4'd5);
    check("mm_digits", digits_entered, 1);
    @(negedge clk);
    clear = 1'b1;
    digit_valid = 1'b1;
    digit = 4'd7;
    #1;
    check("clr_ready", digit_ready, 0);
    @(negedge clk);
    clear = 1'b0;
    digit_valid = 1'b0;
    check("clr_digits", digits_entered, 0);
    enter_code(24'h703262);
    check("reopen_state", state_o, S_OPEN);
    pulse_clear();

    // Non-BCD digit goes to ERROR, fails untouched
    enter_code(24'h999999);
    check("pre_err_fails", fails, 1);
    pulse_clear();
    send_digit(4'd7);
    send_digit(4'd12);
    check("err_state", state_o, S_ERROR);
    check("err_fails", fails, 1);
    check("err_ready", digit_ready, 0);
    pulse_clear();
    check("err_clr_state", state_o, S_ENTRY);
    check("err_clr_digits", digits_entered, 0);

    // Reset mid-entry
    send_digit(4'd7);
    send_digit(4'd0);
    send_digit(4'd3);
    check("mid_digits", digits_entered, 3);
    pulse_rst();
    check("mid_rst_state", state_o, S_ENTRY);
    check("mid_rst_digits", digits_entered, 0);
    check("mid_rst_fails", fails, 0);
    enter_code(24'h703262);
    check("post_rst_open", state_o, S_OPEN);

`ifdef LOCK_PROG_EN
    // Programming: prog beats clear, non-BCD is skipped
    @(negedge clk);
    prog = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    prog = 1'b0;
    clear = 1'b0;
    check("prog_state", state_o, S_PROG);
    check("prog_ready", digit_ready, 1);
    send_digit(4'd1);
    send_digit(4'd12);
    check("prog_reject", digits_entered, 1);
    for (int i = 0; i < 5; i++) send_digit(4'd1);
    check("prog_done", state_o, S_CLOSED);
    pulse_clear();
    enter_code(24'h111111);
    check("new_code_open", state_o, S_OPEN);
    pulse_clear();
    enter_code(24'h703262);
    check("old_code_closed", state_o, S_CLOSED);
    pulse_clear();

    // Aborted programming keeps the current code
    enter_code(24'h111111);
    @(negedge clk);
    prog = 1'b1;
    @(negedge clk);
    prog = 1'b0;
    send_digit(4'd4);
    send_digit(4'd4);
    pulse_clear();
    check("abort_state", state_o, S_ENTRY);
    enter_code(24'h111111);
    check("abort_keep", state_o, S_OPEN);

    // Reset restores the default code
    pulse_rst();
    enter_code(24'h703262);
    check("rst_code", state_o, S_OPEN);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
